gf256_pow_ctrl: RTL and testbench

//  Sequencer that computes base^exp in GF(2^8), p(x)=x^8+x^4+x^3+x^2+1 (0x11D).

---
 rtl/gf256_pkg.sv | 16 +
 rtl/gf256_pow_ctrl_if.sv | 24 ++
 rtl/gf256_mul_core.sv | 23 ++
 rtl/gf256_pow_ctrl.sv | 106 ++++++++++
 tb/tb_gf256_pow_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf256_pkg.sv
// GF(2^8) field constants and sequencer state encoding.
// Shared by the exponentiation controller and its multiplier.
package gf256_pkg;

  localparam int GF_M = 8;
  localparam logic [GF_M:0] GF_POLY = 9'h11D;
  localparam logic [GF_M-1:0] GF_ONE = 8'h01;
  localparam logic [GF_M-1:0] GF_INV_EXP = 8'd254;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2
  } state_e;

endpackage

// File: rtl/gf256_pow_ctrl_if.sv
// Request/response bundle of the GF(2^8) power engine.
// Requester drives start/inv/base/exp, engine returns status.
interface gf256_pow_ctrl_if;
  import gf256_pkg::*;

  logic            start;
  logic            inv;
  logic [GF_M-1:0] base;
  logic [GF_M-1:0] exp;
  logic            busy;
  logic            done;
  logic [GF_M-1:0] result;

  modport master (
    output start, inv, base, exp,
    input  busy, done, result
  );

  modport slave (
    input  start, inv, base, exp,
    output busy, done, result
  );

endinterface

// File: rtl/gf256_mul_core.sv
// Combinational polynomial-basis GF(2^8) multiplier.
// Shift-and-add with reduction by the field polynomial.
module gf256_mul_core
  import gf256_pkg::*;
(
  input  logic [GF_M-1:0] a,
  input  logic [GF_M-1:0] b,
  output logic [GF_M-1:0] p
);

  logic [GF_M-1:0] aa;

  always_comb begin
    p  = '0;
    aa = a;
    for (int i = 0; i < GF_M; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[GF_M-2:0], 1'b0}
         ^ (aa[GF_M-1] ? GF_POLY[GF_M-1:0] : '0);
    end
  end

endmodule

// File: rtl/gf256_pow_ctrl.sv
// MSB-first square-and-multiply sequencer for a^e in GF(2^8).
// One shared multiplier; exp=254 gives the field inverse.
module gf256_pow_ctrl
  import gf256_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  gf256_pow_ctrl_if.slave   bus
);

  state_e          state_q, state_d;
  logic [GF_M-1:0] acc_q, acc_d;
  logic [GF_M-1:0] base_q, base_d;
  logic [GF_M-1:0] exp_q, exp_d;
  logic [GF_M-1:0] result_q, result_d;
  logic [2:0]      idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [GF_M-1:0] mul_b;
  logic [GF_M-1:0] mul_p;

  assign mul_b = (state_q == MUL) ? base_q : acc_q;

  gf256_mul_core u_mul (
    .a (acc_q),
    .b (mul_b),
    .p (mul_p)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    exp_d    = exp_q;
    result_d = result_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d  = bus.base;
          exp_d   = bus.inv ? GF_INV_EXP : bus.exp;
          acc_d   = GF_ONE;
          idx_d   = 3'd7;
          state_d = SQR;
          busy_d  = 1'b1;
        end
      end
      SQR: begin
        acc_d = mul_p;
        if (exp_q[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == 3'd0) begin
          result_d = mul_p;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      MUL: begin
        acc_d = mul_p;
        if (idx_q == 3'd0) begin
          result_d = mul_p;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          idx_d   = idx_q - 3'd1;
          state_d = SQR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      result_q <= '0;
      idx_q    <= 3'd7;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_gf256_pow_ctrl.sv
// Self-checking bench for gf256_pow_ctrl against a log/antilog model.
module tb_gf256_pow_ctrl;

  logic clk;
  logic rst_n;
  gf256_pow_ctrl_if bus ();

  gf256_pow_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;
  int alog [0:254];
  int glog [0:255];

  function automatic int xtime(input int v);
    int r;
    r = (v << 1) & 8'hFF;
    if (v & 8'h80) r = r ^ 8'h1D;
    return r;
  endfunction

  function automatic logic [7:0] ref_pow(input logic [7:0] b,
                                         input logic [7:0] e);
    if (e == 8'd0) return 8'h01;
    if (b == 8'd0) return 8'h00;
    return 8'(alog[(glog[b] * int'(e)) % 255]);
  endfunction

  task automatic build_tables();
    alog[0] = 1;
    for (int i = 1; i < 255; i++) alog[i] = xtime(alog[i-1]);
    for (int i = 0; i < 256; i++) glog[i] = 0;
    for (int i = 0; i < 255; i++) glog[alog[i]] = i;
  endtask

  // Launch one request; return result, cycles to done, busy sanity.
  task automatic run_op(input logic [7:0] b, input logic [7:0] e,
                        input logic iv, output logic [7:0] res,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = b;
    bus.exp   = e;
    bus.inv   = iv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.base  = 8'($urandom);
    bus.exp   = 8'($urandom);
    bus.inv   = 1'($urandom);
    busy_ok = bus.busy;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
      if (!bus.busy) busy_ok = 1'b0;
    end
    if (bus.done && bus.busy) busy_ok = 1'b0;
    if (!bus.done) lat = 99;
    res = bus.result;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.result !== 8'h00) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h want 0 0 00",
               bus.busy, bus.done, bus.result);
    end
  endtask

  task automatic check_op(input string name, input logic [7:0] b,
                          input logic [7:0] e, input logic iv,
                          input logic [7:0] want, input int want_lat);
    logic [7:0] r;
    int l;
    logic bok;
    run_op(b, e, iv, r, l, bok);
    checks++;
    if (r !== want) begin
      errors++;
      $display("FAIL %s result: got %h want %h", name, r, want);
    end
    checks++;
    if (l !== want_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, l, want_lat);
    end
    checks++;
    if (bok !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: got %b want 1 until done", name, bok);
    end
  endtask

  task automatic test_basic();
    check_op("x8", 8'h02, 8'd8, 1'b0, 8'h1D, 9);
    check_op("inv2", 8'h02, 8'hFF, 1'b1, 8'h8E, 15);
    check_op("inv0", 8'h00, 8'h05, 1'b1, 8'h00, 15);
    check_op("e0", 8'h53, 8'd0, 1'b0, 8'h01, 8);
    check_op("zero0", 8'h00, 8'd0, 1'b0, 8'h01, 8);
    check_op("e255", 8'h02, 8'd255, 1'b0, 8'h01, 16);
    check_op("b0e7", 8'h00, 8'd7, 1'b0, 8'h00, 11);
  endtask

  task automatic test_start_busy();
    int dones;
    logic [7:0] r;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = 8'h03;
    bus.exp   = 8'd5;
    bus.inv   = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    dones = 0;
    r = 8'h00;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) begin
        bus.start = 1'b1;
        bus.base  = 8'h07;
        bus.exp   = 8'd200;
      end
      if (k == 4) bus.start = 1'b0;
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        r = bus.result;
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL busy_start dones: got %0d want 1", dones);
    end
    checks++;
    if (r !== ref_pow(8'h03, 8'd5)) begin
      errors++;
      $display("FAIL busy_start result: got %h want %h",
               r, ref_pow(8'h03, 8'd5));
    end
  endtask

  task automatic test_back_to_back();
    int l1;
    int l2;
    logic [7:0] r1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = 8'h1B;
    bus.exp   = 8'd3;
    bus.inv   = 1'b0;
    @(posedge clk);
    #1;
    bus.base = 8'h45;
    bus.exp  = 8'd0;
    bus.inv  = 1'b1;
    l1 = 0;
    while (l1 < 40) begin
      @(posedge clk);
      #1;
      l1++;
      if (bus.done) break;
    end
    r1 = bus.result;
    checks++;
    if (r1 !== ref_pow(8'h1B, 8'd3) || l1 !== 10) begin
      errors++;
      $display("FAIL b2b first: got %h lat %0d want %h lat 10",
               r1, l1, ref_pow(8'h1B, 8'd3));
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    l2 = 0;
    while (l2 < 40) begin
      @(posedge clk);
      #1;
      l2++;
      if (bus.done) break;
    end
    checks++;
    if (bus.result !== ref_pow(8'h45, 8'd254) || l2 !== 15) begin
      errors++;
      $display("FAIL b2b second: got %h lat %0d want %h lat 15",
               bus.result, l2, ref_pow(8'h45, 8'd254));
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    check_op("pre_rst", 8'h09, 8'd2, 1'b0, ref_pow(8'h09, 8'd2), 9);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = 8'h11;
    bus.inv   = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.result !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b result=%h want 0 0 00",
               bus.busy, bus.done, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL mid_reset dones: got %0d want 0", dones);
    end
    check_op("post_rst", 8'h11, 8'd0, 1'b1, ref_pow(8'h11, 8'd254), 15);
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] e;
    logic iv;
    logic [7:0] r;
    logic [7:0] ee;
    int l;
    logic bok;
    for (int n = 0; n < 3000; n++) begin
      b  = 8'($urandom);
      e  = 8'($urandom);
      iv = ($urandom_range(0, 7) == 0);
      if (n % 50 == 0) b = 8'h00;
      ee = iv ? 8'd254 : e;
      run_op(b, e, iv, r, l, bok);
      checks++;
      if (r !== ref_pow(b, ee) || l !== 8 + $countones(ee) ||
          bok !== 1'b1) begin
        errors++;
        $display("FAIL rand b=%h e=%h inv=%b: got %h lat %0d busy %b want %h lat %0d",
                 b, e, iv, r, l, bok, ref_pow(b, ee), 8 + $countones(ee));
      end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.inv   = 1'b0;
    bus.base  = 8'h00;
    bus.exp   = 8'h00;
    build_tables();
    repeat (3) @(posedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
